// File: rtl/key_event_ctrl.sv
// ---------------------------------------------------------------------------
// key_event_ctrl
//   Multi-channel key debouncer and press-event generator. Each of W active-low
//   mechanical keys is synchronised, then qualified by its own one-hot
//   IDLE/DOWN/HOLD/UP FSM. The FSM produces a clean level, one-cycle
//   press/release strobes, a long-press strobe and, optionally, an
//   auto-repeat strobe.
//
//   Optional feature macro: KEY_REPEAT_EN
//     defined   : key_repeat pulses every TIME_REP held cycles after key_long
//     undefined : repeat counter is not built and key_repeat is tied to 0
//
// Parameters
//   W          number of independent key channels (>= 1)
//   TIME_DEB   debounce window in clocks (>= 2)
//   TIME_LONG  hold time in clocks before key_long fires (>= 2)
//   TIME_REP   auto-repeat period in clocks (>= 2)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_in       raw asynchronous key pins, 0 = pressed
//   key_level    debounced level, 0 = pressed (resets to all 1)
//   key_press    one-cycle strobe on a confirmed press
//   key_release  one-cycle strobe on a confirmed release
//   key_long     one-cycle strobe once per press when the hold reaches TIME_LONG
//   key_repeat   one-cycle auto-repeat strobe
// ---------------------------------------------------------------------------
module key_event_ctrl #(
  parameter int W         = 3,
  parameter int TIME_DEB  = 1_000_000,
  parameter int TIME_LONG = 50_000_000,
  parameter int TIME_REP  = 10_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] key_in,
  output logic [W-1:0] key_level,
  output logic [W-1:0] key_press,
  output logic [W-1:0] key_release,
  output logic [W-1:0] key_long,
  output logic [W-1:0] key_repeat
);

  localparam int CNT_W  = $clog2(TIME_DEB);
  localparam int HOLD_W = $clog2(TIME_LONG);

  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(TIME_DEB - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(TIME_LONG - 1);

`ifdef KEY_REPEAT_EN
  localparam int               REP_W    = $clog2(TIME_REP);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(TIME_REP - 1);
`endif

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    DOWN = 4'b0010,
    HOLD = 4'b0100,
    UP   = 4'b1000
  } state_t;

  // Two-flop synchronizer; idles high so reset exit looks like "released".
  logic [W-1:0] sync1_reg;
  logic [W-1:0] sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_ch
      logic              s;
      state_t            state_reg, state_next;
      logic [CNT_W-1:0]  cnt_reg, cnt_next;
      logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
      logic              long_done_reg, long_done_next;
      logic              level_reg, level_next;
      logic              press_reg, press_next;
      logic              release_reg, release_next;
      logic              long_reg, long_next;
`ifdef KEY_REPEAT_EN
      logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
      logic              repeat_reg, repeat_next;
`endif

      assign s = sync2_reg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          hold_cnt_reg  <= '0;
          long_done_reg <= 1'b0;
          level_reg     <= 1'b1;
          press_reg     <= 1'b0;
          release_reg   <= 1'b0;
          long_reg      <= 1'b0;
`ifdef KEY_REPEAT_EN
          rep_cnt_reg   <= '0;
          repeat_reg    <= 1'b0;
`endif
        end else begin
          state_reg     <= state_next;
          cnt_reg       <= cnt_next;
          hold_cnt_reg  <= hold_cnt_next;
          long_done_reg <= long_done_next;
          level_reg     <= level_next;
          press_reg     <= press_next;
          release_reg   <= release_next;
          long_reg      <= long_next;
`ifdef KEY_REPEAT_EN
          rep_cnt_reg   <= rep_cnt_next;
          repeat_reg    <= repeat_next;
`endif
        end
      end

      always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        long_done_next = long_done_reg;
        level_next     = level_reg;
        press_next     = 1'b0;
        release_next   = 1'b0;
        long_next      = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt_next   = rep_cnt_reg;
        repeat_next    = 1'b0;
`endif
        unique case (state_reg)
          IDLE: begin
            cnt_next       = '0;
            hold_cnt_next  = '0;
            long_done_next = 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt_next   = '0;
`endif
            if (!s) begin
              state_next = DOWN;
            end
          end

          DOWN: begin
            if (s) begin
              // Glitch shorter than the window: drop it silently.
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == DEB_LAST) begin
              state_next    = HOLD;
              cnt_next      = '0;
              hold_cnt_next = '0;
              press_next    = 1'b1;
              level_next    = 1'b0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end

          HOLD: begin
            if (s) begin
              state_next = UP;
              cnt_next   = '0;
            end else begin
              if (hold_cnt_reg == LONG_LAST && !long_done_reg) begin
                long_next      = 1'b1;
                long_done_next = 1'b1;
              end
              // Saturate at the long-press point; long_done blocks a re-fire.
              if (hold_cnt_reg != LONG_LAST) begin
                hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
              end
`ifdef KEY_REPEAT_EN
              // Repeat period starts the cycle after key_long.
              if (long_done_reg) begin
                if (rep_cnt_reg == REP_LAST) begin
                  repeat_next  = 1'b1;
                  rep_cnt_next = '0;
                end else begin
                  rep_cnt_next = rep_cnt_reg + REP_W'(1);
                end
              end
`endif
            end
          end

          UP: begin
            if (!s) begin
              // Release bounce: still held; hold/repeat counters were frozen.
              state_next = HOLD;
              cnt_next   = '0;
            end else if (cnt_reg == DEB_LAST) begin
              state_next   = IDLE;
              cnt_next     = '0;
              release_next = 1'b1;
              level_next   = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end

          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      assign key_level[gi]   = level_reg;
      assign key_press[gi]   = press_reg;
      assign key_release[gi] = release_reg;
      assign key_long[gi]    = long_reg;
`ifdef KEY_REPEAT_EN
      assign key_repeat[gi]  = repeat_reg;
`else
      // Repeat disabled: the port stays for pin compatibility and reads 0;
      // TIME_REP has no effect in this build (the term below is constant 0).
      assign key_repeat[gi]  = 1'b0 & (TIME_REP != 0);
`endif
    end
  endgenerate

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Multi-channel key debouncer and press-event generator, the next generation of the team's single-mode key FSM. Each of `W` active-low mechanical keys gets its own four-state debounce FSM plus a hold timer, producing a clean level, one-cycle press/release strobes, a long-press strobe and an optional auto-repeat strobe. It sits between the board key pins and application logic such as the beeper and menu controllers, which consume strobes instead of raw levels.

## Interface
- `W`, default 3: number of independent key channels (≥1).
- `TIME_DEB`, default 1_000_000: debounce window in clocks (20 ms at 50 MHz), ≥2.
- `TIME_LONG`, default 50_000_000: hold time in clocks before the long-press strobe fires (1 s at 50 MHz), ≥2.
- `TIME_REP`, default 10_000_000: auto-repeat period in clocks (200 ms), ≥2; used only with `KEY_REPEAT_EN`.

- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `key_in`, input, W: raw asynchronous key pins, 0 = pressed.
- `key_level`, output, W: debounced level, 0 = pressed; resets to all 1.
- `key_press`, output, W: one-cycle strobe on a confirmed press; resets to 0.
- `key_release`, output, W: one-cycle strobe on a confirmed release; resets to 0.
- `key_long`, output, W: one-cycle strobe, at most once per press, when the hold reaches `TIME_LONG`; resets to 0.
- `key_repeat`, output, W: one-cycle auto-repeat strobe; resets to 0.

## Operation
- Per channel i, a 2-flop synchronizer (both flops reset to 1) gives `s[i]`. All FSM decisions use `s[i]` only.
- Each channel has its own FSM. States are IDLE, DOWN, HOLD and UP, one-hot, and reset to IDLE.
  - IDLE: when `s`=0, go to DOWN with `cnt`=0.
  - DOWN: when `s`=1, go to IDLE and emit nothing (rejected glitch). Otherwise `cnt`++. When `cnt`==`TIME_DEB`-1, go to HOLD, pulse `key_press` and drive `key_level`=0.
  - HOLD: when `s`=1, go to UP with `cnt`=0. Otherwise `hold_cnt` runs.
  - UP: when `s`=0, return to HOLD (release bounce); no strobe, and `key_level` stays 0. Otherwise `cnt`++. When `cnt`==`TIME_DEB`-1, go to IDLE, pulse `key_release` and drive `key_level`=1.
- `hold_cnt` behaviour:
  - Clears on the DOWN→HOLD transition.
  - Increments only in HOLD and freezes in UP.
  - When `hold_cnt`==`TIME_LONG`-1 and `long_done`=0, pulse `key_long` and set `long_done`.
  - `long_done` clears in IDLE.
  - `hold_cnt` saturates and does not wrap.
- `cnt` width is $clog2(`TIME_DEB`). `hold_cnt` and `rep_cnt` widths come from `TIME_LONG` and `TIME_REP`. Counters compare with ==, never overflow and clear when leaving their state.
- Channels are fully independent. Simultaneous events on several channels all strobe in the same cycle.
- No strobe is ever emitted in a state other than the one named above.

## Timing
- All outputs are registered.
- Clean press with `key_in` falling before edge 1:
  - `s` low after edge 2; DOWN entered at edge 3.
  - `key_press`=1 and `key_level`=0 in the cycle after edge `TIME_DEB`+3.
- Release has symmetric latency: `key_release` is high in the cycle after edge `TIME_DEB`+3 counted from `key_in` rising.
- `key_long` follows `key_press` by `TIME_LONG` cycles, provided there is no UP excursion.
- Any `s` toggle inside a debounce window restarts qualification: DOWN falls back to IDLE, and UP falls back to HOLD.
- `rst_n` low at any time (mid-DOWN, HOLD or UP) immediately forces IDLE, clears all counters and flags, drives all strobes to 0 and `key_level` to all 1. No strobes are generated on reset exit.

## Configuration
- `KEY_REPEAT_EN` defined:
  - After `key_long`, `rep_cnt` runs in HOLD.
  - `key_repeat` pulses every `TIME_REP` cycles; the first pulse comes `TIME_REP` cycles after `key_long`.
  - `rep_cnt` freezes in UP and clears in IDLE.
- `KEY_REPEAT_EN` undefined: `rep_cnt` logic is not compiled, and the `key_repeat` port remains and is tied to 0.

## Test plan
- Sim params for all tests: W=3, `TIME_DEB`=4, `TIME_LONG`=20, `TIME_REP`=8.
- Clean press and release on ch0 (key held 10 cycles):
  - `key_press[0]` is high exactly 1 cycle, 7 cycles after the fall.
  - `key_release[0]` is high 1 cycle, 7 cycles after the rise.
  - `key_long` stays 0; other channels are silent.
- Bounce on ch1: `key_in[1]` toggles 0/1 every 2 cycles for 12 cycles, then stays 0.
  - Exactly one `key_press[1]`, only after the stable low.
  - No `key_release` during the bounce.
- Long press with `KEY_REPEAT_EN` on ch2 held 60 cycles: one `key_press`, then `key_long` 20 cycles later, then `key_repeat` every 8 cycles until the release is confirmed.
- Same long press without `KEY_REPEAT_EN`: `key_long` fires once and `key_repeat` stays 0 throughout.
- All three keys pressed on the same cycle: `key_press` equals 3'b111 in one single cycle, and `key_level` equals 3'b000.
- `rst_n` pulsed low while ch0 is in HOLD: outputs are 0 and `key_level` is 3'b111 immediately; no `key_release` is emitted after reset.
